// File: rtl/cond_unit.sv
// ---------------------------------------------------------------------------
// cond_unit
//
// Purpose:
//   Execute-stage condition unit for an ARM-style pipeline. It holds the
//   NZCV flags register, evaluates the instruction condition field against
//   it, conditionally updates the flags, and registers the gated write/branch
//   enables that travel on to the next stage.
//
// Ports:
//   clk        in   1  rising-edge clock
//   reset      in   1  asynchronous, active-high reset
//   in_valid   in   1  an instruction occupies the execute stage this cycle
//   stall      in   1  hold the output stage and suppress flag writes
//   flush      in   1  squash the current instruction (beats stall)
//   cond       in   4  condition field, instr[31:28]
//   s_bit      in   1  instruction requests a flag update
//   flag_wr    in   2  [1] selects the N,Z group, [0] selects the C,V group
//   alu_flags  in   4  ALU result flags {N,Z,C,V}
//   reg_we_in  in   1  ungated register-write enable from decode
//   mem_we_in  in   1  ungated memory-write enable from decode
//   pc_src_in  in   1  ungated PC-source select from decode
//   cond_ex    out  1  combinational condition-check result
//   flags      out  4  registered {N,Z,C,V}
//   carry      out  1  flags[1], feeds the ALU carry-in
//   valid_q    out  1  registered instruction-valid for the next stage
//   reg_we     out  1  registered, condition-gated register-write enable
//   mem_we     out  1  registered, condition-gated memory-write enable
//   pc_src     out  1  registered, condition-gated PC-source select
// ---------------------------------------------------------------------------
module cond_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic       stall,
    input  logic       flush,
    input  logic [3:0] cond,
    input  logic       s_bit,
    input  logic [1:0] flag_wr,
    input  logic [3:0] alu_flags,
    input  logic       reg_we_in,
    input  logic       mem_we_in,
    input  logic       pc_src_in,
    output logic       cond_ex,
    output logic [3:0] flags,
    output logic       carry,
    output logic       valid_q,
    output logic       reg_we,
    output logic       mem_we,
    output logic       pc_src
);

    logic [3:0] flags_q, flags_d;
    logic       stageValid_q, stageValid_d;
    logic       stageRegWe_q, stageRegWe_d;
    logic       stageMemWe_q, stageMemWe_d;
    logic       stagePcSrc_q, stagePcSrc_d;
    logic       flagN, flagZ, flagC, flagV;
    logic       doUpdate;

    assign flagN = flags_q[3];
    assign flagZ = flags_q[2];
    assign flagC = flags_q[1];
    assign flagV = flags_q[0];

    // Condition check against the flags as they stand this cycle. Because the
    // flags register is read directly (not a pipelined copy), an update made
    // at the previous edge is already visible here, so back-to-back
    // flag-setting and flag-testing instructions need no bubble.
    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'h0: cond_ex = flagZ;
            4'h1: cond_ex = !flagZ;
            4'h2: cond_ex = flagC;
            4'h3: cond_ex = !flagC;
            4'h4: cond_ex = flagN;
            4'h5: cond_ex = !flagN;
            4'h6: cond_ex = flagV;
            4'h7: cond_ex = !flagV;
            4'h8: cond_ex = flagC && !flagZ;
            4'h9: cond_ex = !flagC || flagZ;
            4'hA: cond_ex = (flagN == flagV);
            4'hB: cond_ex = (flagN != flagV);
            4'hC: cond_ex = !flagZ && (flagN == flagV);
            4'hD: cond_ex = flagZ || (flagN != flagV);
            4'hE: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    assign doUpdate = in_valid & cond_ex & s_bit & ~stall & ~flush;

    // Flag next-state: the N,Z and C,V groups are written independently so
    // instructions that only define some flags (e.g. logical ops leaving V)
    // preserve the rest.
    always_comb begin
        flags_d = flags_q;
        if (doUpdate) begin
            if (flag_wr[1]) flags_d[3:2] = alu_flags[3:2];
            if (flag_wr[0]) flags_d[1:0] = alu_flags[1:0];
        end
    end

    // Output stage next-state: flush squashes even while stalled; a stall
    // freezes the stage; otherwise the enables are gated by validity and the
    // condition result.
    always_comb begin
        stageValid_d = stageValid_q;
        stageRegWe_d = stageRegWe_q;
        stageMemWe_d = stageMemWe_q;
        stagePcSrc_d = stagePcSrc_q;
        if (flush) begin
            stageValid_d = 1'b0;
            stageRegWe_d = 1'b0;
            stageMemWe_d = 1'b0;
            stagePcSrc_d = 1'b0;
        end else if (!stall) begin
            stageValid_d = in_valid;
            stageRegWe_d = in_valid & cond_ex & reg_we_in;
            stageMemWe_d = in_valid & cond_ex & mem_we_in;
            stagePcSrc_d = in_valid & cond_ex & pc_src_in;
        end
    end

    // All state registers, cleared immediately by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q      <= 4'b0000;
            stageValid_q <= 1'b0;
            stageRegWe_q <= 1'b0;
            stageMemWe_q <= 1'b0;
            stagePcSrc_q <= 1'b0;
        end else begin
            flags_q      <= flags_d;
            stageValid_q <= stageValid_d;
            stageRegWe_q <= stageRegWe_d;
            stageMemWe_q <= stageMemWe_d;
            stagePcSrc_q <= stagePcSrc_d;
        end
    end

    assign flags   = flags_q;
    assign carry   = flags_q[1];
    assign valid_q = stageValid_q;
    assign reg_we  = stageRegWe_q;
    assign mem_we  = stageMemWe_q;
    assign pc_src  = stagePcSrc_q;

endmodule

// File: tb/tb_cond_unit.sv
// ---------------------------------------------------------------------------
// tb_cond_unit
//
// Self-checking bench for cond_unit. The driver issues one instruction per
// cycle and pushes the hand-computed output state expected after that edge
// into a queue; an independent monitor pops one entry per cycle and compares
// it against the registered outputs. cond_ex is combinational and is checked
// directly by the driver.
// ---------------------------------------------------------------------------
module tb_cond_unit;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       stall;
    logic       flush;
    logic [3:0] cond;
    logic       s_bit;
    logic [1:0] flag_wr;
    logic [3:0] alu_flags;
    logic       reg_we_in;
    logic       mem_we_in;
    logic       pc_src_in;
    logic       cond_ex;
    logic [3:0] flags;
    logic       carry;
    logic       valid_q;
    logic       reg_we;
    logic       mem_we;
    logic       pc_src;

    typedef struct {
        string      name;
        logic [3:0] flags;
        logic       valid;
        logic       regWe;
        logic       memWe;
        logic       pcSrc;
    } expect_t;

    expect_t expQ[$];
    int      checks   = 0;
    int      failures = 0;

    cond_unit dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .stall     (stall),
        .flush     (flush),
        .cond      (cond),
        .s_bit     (s_bit),
        .flag_wr   (flag_wr),
        .alu_flags (alu_flags),
        .reg_we_in (reg_we_in),
        .mem_we_in (mem_we_in),
        .pc_src_in (pc_src_in),
        .cond_ex   (cond_ex),
        .flags     (flags),
        .carry     (carry),
        .valid_q   (valid_q),
        .reg_we    (reg_we),
        .mem_we    (mem_we),
        .pc_src    (pc_src)
    );

    // 10-unit clock period, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared comparison helper used by both driver and monitor.
    task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference condition evaluation, built the way the architecture manual
    // describes it: cond[3:1] picks a base test, cond[0] inverts it, and
    // 4'hF is special-cased to never execute.
    function automatic logic condRef(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, base;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf & ~z;
            3'd5: base = (n == v);
            3'd6: base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        if (c == 4'hF) return 1'b0;
        return base ^ c[0];
    endfunction

    // Drive one cycle of stimulus (called at posedge+2), check cond_ex,
    // queue the expected post-edge state, and return at the next posedge+2.
    task automatic applyStimulus(
        input string      name,
        input logic       iv, st, fl,
        input logic [3:0] c,
        input logic       s,
        input logic [1:0] fw,
        input logic [3:0] alu,
        input logic       rwe, mwe, psrc,
        input logic       expCondEx,
        input logic [3:0] expFlags,
        input logic       expV, expR, expM, expP
    );
        expect_t e;
        in_valid  = iv;
        stall     = st;
        flush     = fl;
        cond      = c;
        s_bit     = s;
        flag_wr   = fw;
        alu_flags = alu;
        reg_we_in = rwe;
        mem_we_in = mwe;
        pc_src_in = psrc;
        #1;
        checkOutput({name, ".cond_ex"}, {3'b0, cond_ex}, {3'b0, expCondEx});
        e.name  = name;
        e.flags = expFlags;
        e.valid = expV;
        e.regWe = expR;
        e.memWe = expM;
        e.pcSrc = expP;
        expQ.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // Monitor: one output snapshot per clock, compared against the oldest
    // queued expectation.
    always begin
        expect_t e;
        @(posedge clk);
        #1;
        if (!reset && expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput({e.name, ".flags"},   flags,            e.flags);
            checkOutput({e.name, ".carry"},   {3'b0, carry},    {3'b0, e.flags[1]});
            checkOutput({e.name, ".valid_q"}, {3'b0, valid_q},  {3'b0, e.valid});
            checkOutput({e.name, ".reg_we"},  {3'b0, reg_we},   {3'b0, e.regWe});
            checkOutput({e.name, ".mem_we"},  {3'b0, mem_we},   {3'b0, e.memWe});
            checkOutput({e.name, ".pc_src"},  {3'b0, pc_src},   {3'b0, e.pcSrc});
        end
    end

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] f;
        reset     = 1'b1;
        in_valid  = 1'b0;
        stall     = 1'b0;
        flush     = 1'b0;
        cond      = 4'h0;
        s_bit     = 1'b0;
        flag_wr   = 2'b00;
        alu_flags = 4'h0;
        reg_we_in = 1'b0;
        mem_we_in = 1'b0;
        pc_src_in = 1'b0;

        // Reset state while reset is held.
        repeat (2) @(posedge clk);
        #2;
        checkOutput("rst.flags",   flags,           4'h0);
        checkOutput("rst.carry",   {3'b0, carry},   4'h0);
        checkOutput("rst.valid_q", {3'b0, valid_q}, 4'h0);
        checkOutput("rst.reg_we",  {3'b0, reg_we},  4'h0);
        checkOutput("rst.mem_we",  {3'b0, mem_we},  4'h0);
        checkOutput("rst.pc_src",  {3'b0, pc_src},  4'h0);
        reset = 1'b0;

        // After release: EQ reads 0, NE reads 1.
        cond = 4'h0; #1;
        checkOutput("rst.eq", {3'b0, cond_ex}, 4'h0);
        cond = 4'h1; #1;
        checkOutput("rst.ne", {3'b0, cond_ex}, 4'h1);
        @(posedge clk);
        #2;

        //            name        iv st fl cond s  fw     alu    rwe mwe psrc cex  expFlags v r m p
        applyStimulus("upd",      1, 0, 0, 4'hE, 1, 2'b11, 4'h6, 1, 0, 0,   1,  4'h6,    1,1,0,0);
        applyStimulus("setZ",     1, 0, 0, 4'hE, 1, 2'b11, 4'h4, 0, 1, 0,   1,  4'h4,    1,0,1,0);
        applyStimulus("b2b.eq",   1, 0, 0, 4'h0, 0, 2'b00, 4'h0, 1, 0, 0,   1,  4'h4,    1,1,0,0);
        applyStimulus("b2b.ne",   1, 0, 0, 4'h1, 0, 2'b00, 4'h0, 1, 0, 1,   0,  4'h4,    1,0,0,0);
        applyStimulus("set0011",  1, 0, 0, 4'hE, 1, 2'b11, 4'h3, 0, 0, 0,   1,  4'h3,    1,0,0,0);
        applyStimulus("partNZ",   1, 0, 0, 4'hE, 1, 2'b10, 4'h8, 0, 0, 1,   1,  4'hB,    1,0,0,1);
        applyStimulus("partCV",   1, 0, 0, 4'hE, 1, 2'b01, 4'h0, 0, 0, 0,   1,  4'h8,    1,0,0,0);
        applyStimulus("reset1011",1, 0, 0, 4'hE, 1, 2'b01, 4'h3, 0, 0, 0,   1,  4'hB,    1,0,0,0);
        applyStimulus("failEQ",   1, 0, 0, 4'h0, 1, 2'b11, 4'h4, 1, 1, 1,   0,  4'hB,    1,0,0,0);
        applyStimulus("noValid",  0, 0, 0, 4'hE, 1, 2'b11, 4'h0, 1, 1, 1,   1,  4'hB,    0,0,0,0);
        applyStimulus("preStall", 1, 0, 0, 4'hE, 0, 2'b00, 4'h0, 1, 1, 0,   1,  4'hB,    1,1,1,0);
        applyStimulus("stall1",   1, 1, 0, 4'hE, 1, 2'b11, 4'h0, 0, 0, 1,   1,  4'hB,    1,1,1,0);
        applyStimulus("stall2",   0, 1, 0, 4'hE, 1, 2'b11, 4'h0, 0, 0, 1,   1,  4'hB,    1,1,1,0);
        applyStimulus("flushStl", 1, 1, 1, 4'hE, 1, 2'b11, 4'h0, 1, 1, 1,   1,  4'hB,    0,0,0,0);
        applyStimulus("flushOnly",1, 0, 1, 4'hE, 1, 2'b11, 4'h0, 1, 1, 1,   1,  4'hB,    0,0,0,0);

        // Sweep every flag combination against every condition code; cond=F
        // must never execute nor touch the flags.
        for (int fi = 0; fi < 16; fi++) begin
            f = fi[3:0];
            applyStimulus("sweepLoad", 1, 0, 0, 4'hE, 1, 2'b11, f, 0, 0, 0, 1, f, 1, 0, 0, 0);
            in_valid = 1'b0;
            s_bit    = 1'b0;
            for (int ci = 0; ci < 16; ci++) begin
                cond = ci[3:0];
                #0.1;
                checkOutput($sformatf("sweep.c%0h.f%0h", ci, fi), {3'b0, cond_ex}, {3'b0, condRef(ci[3:0], f)});
            end
            applyStimulus("sweepNV", 1, 0, 0, 4'hF, 1, 2'b11, ~f, 1, 1, 1, 0, f, 1, 0, 0, 0);
        end

        // Asynchronous reset between edges.
        applyStimulus("set1111", 1, 0, 0, 4'hE, 1, 2'b11, 4'hF, 1, 0, 0, 1, 4'hF, 1, 1, 0, 0);
        in_valid = 1'b0;
        s_bit    = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        checkOutput("arst.flags",   flags,           4'h0);
        checkOutput("arst.carry",   {3'b0, carry},   4'h0);
        checkOutput("arst.reg_we",  {3'b0, reg_we},  4'h0);
        checkOutput("arst.valid_q", {3'b0, valid_q}, 4'h0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #2;

        checkOutput("queueDrained", expQ.size() == 0 ? 4'h0 : 4'h1, 4'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
